// File: rtl/multicycle_adder.sv
// multicycle_adder: add/subtract two WIDTH-bit operands CHUNK bits per clock through a short ripple slice
`timescale 1ns/1ps
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CHUNK-1:0] sl_a, sl_b, sl_s;
   logic [CHUNK:0]   c;
   logic             accept, last;

   assign accept = start && (state_q != RUN);
   assign last   = (idx_q == IW'(N - 1));
   assign sl_a   = a_q[idx_q*CHUNK +: CHUNK];
   assign sl_b   = b_q[idx_q*CHUNK +: CHUNK];

   // CHUNK-bit ripple of full adders on the current slice, fed by the registered carry
   always_comb begin
      c    = '0;
      sl_s = '0;
      c[0] = carry_q;
      for (int j = 0; j < CHUNK; j++) begin
         sl_s[j]  = sl_a[j] ^ sl_b[j] ^ c[j];
         c[j+1]   = (sl_a[j] & sl_b[j]) | (c[j] & (sl_a[j] ^ sl_b[j]));
      end
   end

   // next state: accept in IDLE/DONE, one slice per RUN cycle, flags captured on the last slice
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
         idx_d   = '0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         sum_d[idx_q*CHUNK +: CHUNK] = sl_s;
         carry_d = c[CHUNK];
         idx_d   = idx_q + 1'b1;
         if (last) begin
            c_out_d = c[CHUNK];
            ovf_d   = c[CHUNK-1] ^ c[CHUNK];
            state_d = DONE;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   // state and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: scoreboard bench for the 16/4 adder plus an exhaustive 4/4 (N=1) instance
`timescale 1ns/1ps
module tb_multicycle_adder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, cin = 1'b0, sub = 1'b0;
   logic [15:0] a = '0, b = '0, sum16;
   logic        busy16, done16, c16, ovf16;
   logic        start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0, sum4;
   logic        busy4, done4, c4, ovf4;
   int          cyc = 0;
   int          n_chk = 0, n_fail = 0;

   typedef struct {logic [15:0] sum; logic c; logic ovf; int at;} exp_t;
   typedef struct {logic [15:0] a, b; logic cin, sub; logic [15:0] sum; logic c, ovf;} vec_t;

   exp_t q16[$], q4[$];
   exp_t e16, e4;

   vec_t vecs[7] = '{
      '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
      '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0}
   };
   vec_t ign  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
   vec_t bb1  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
   vec_t bb2  = '{16'hA000, 16'h6000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
   vec_t abrt = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};

   multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy16), .done(done16), .sum(sum16), .c_out(c16), .ovf(ovf16));

   multicycle_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .busy(busy4), .done(done4), .sum(sum4), .c_out(c4), .ovf(ovf4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done16) begin
         chk("busy16_with_done", busy16, 0);
         if (q16.size() == 0) chk("unexpected_done16", done16, 0);
         else begin
            e16 = q16.pop_front();
            chk("sum16", sum16, e16.sum);
            chk("c_out16", c16, e16.c);
            chk("ovf16", ovf16, e16.ovf);
            chk("latency16", cyc, e16.at);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done4) begin
         if (q4.size() == 0) chk("unexpected_done4", done4, 0);
         else begin
            e4 = q4.pop_front();
            chk("sum4", sum4, e4.sum);
            chk("c_out4", c4, e4.c);
            chk("ovf4", ovf4, e4.ovf);
            chk("latency4", cyc, e4.at);
         end
      end
   end

   task automatic issue16(input vec_t v, input bit expect_it);
      exp_t x;
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
      if (expect_it) begin
         x.sum = v.sum; x.c = v.c; x.ovf = v.ovf; x.at = cyc + 1 + 4;
         q16.push_back(x);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain16();
      for (int i = 0; i < 40 && q16.size() != 0; i++) @(negedge clk);
      if (q16.size() != 0) begin
         chk("drain16_timeout", q16.size(), 0);
         q16.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic issue4(input int av, input int bv, input bit c_in, input bit s);
      exp_t x;
      logic [4:0] r;
      logic [3:0] aa, bb;
      aa = 4'(av); bb = 4'(bv);
      r = s ? ({1'b0, aa} + {1'b0, ~bb} + 5'd1) : ({1'b0, aa} + {1'b0, bb} + {4'd0, c_in});
      @(negedge clk);
      a4 = aa; b4 = bb; cin4 = c_in; sub4 = s; start4 = 1'b1;
      x.sum = {12'd0, r[3:0]}; x.c = r[4];
      x.ovf = s ? ((aa[3] != bb[3]) && (r[3] != aa[3])) : ((aa[3] == bb[3]) && (r[3] != aa[3]));
      x.at = cyc + 1 + 1;
      q4.push_back(x);
      @(negedge clk);
      start4 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 1'b1; a = 16'hFFFF; b = 16'h0001; start4 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_sum", sum16, 0);
      chk("rst_c_out", c16, 0);
      chk("rst_ovf", ovf16, 0);
      chk("rst_busy", busy16, 0);
      chk("rst_done", done16, 0);
      rst_n = 1'b1; start = 1'b0; start4 = 1'b0;
      @(negedge clk);
      chk("post_rst_busy16", busy16, 0);
      chk("post_rst_busy4", busy4, 0);
      for (int i = 0; i < 6; i++) begin
         issue16(vecs[i], 1'b1);
         drain16();
      end
      issue16(vecs[6], 1'b1);
      issue16(ign, 1'b0);
      drain16();
      repeat (4) @(negedge clk);
      issue16(bb1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done16) break;
      end
      a = bb2.a; b = bb2.b; cin = bb2.cin; sub = bb2.sub; start = 1'b1;
      e16.sum = bb2.sum; e16.c = bb2.c; e16.ovf = bb2.ovf; e16.at = cyc + 1 + 4;
      q16.push_back(e16);
      @(negedge clk);
      start = 1'b0;
      drain16();
      issue16(abrt, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      q16.delete();
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_sum", sum16, 0);
      chk("abort_c_out", c16, 0);
      chk("abort_ovf", ovf16, 0);
      chk("abort_busy", busy16, 0);
      chk("abort_done", done16, 0);
      repeat (8) @(negedge clk);
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               for (int ci = 0; ci < 2 - s; ci++)
                  issue4(x, y, ci[0], s[0]);
      for (int i = 0; i < 10 && q4.size() != 0; i++) @(negedge clk);
      if (q4.size() != 0) chk("drain4_timeout", q4.size(), 0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
